wb_arbiter: RTL

- Writeback arbiter. It merges results from the single-cycle ALU pipe, the load/store unit (LSU) and the multiply/divide unit (MDU) into one registered write stream.
- That stream drives the register file write port (wrd/addr_d/d).
- Long-latency results are buffered in a shared FIFO. A starvation counter guarantees the FIFO drains under continuous ALU traffic.
- Sits between the execute/memory stages and the register file. pend_mask feeds hazard detection.

---
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, LSU and MDU results into one registered register-file write stream.
// Optional WB_X0_DROP_EN: results targeting x0 are consumed without being queued or written.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     alu_stall,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [31:0]              lsu_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_rd,
    input  logic [31:0]              mdu_data,
    output logic                     wrd,
    output logic [4:0]               addr_d,
    output logic [31:0]              d,
    output logic [31:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_ent_t;

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    wb_ent_t          mem_q [DEPTH];
    wb_ent_t          mem_d [DEPTH];
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             wen_q, wen_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic    empty, full, push, push_en, pop, starve;
    wb_ent_t push_ent, head_ent;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign lsu_ready  = !full;
    assign mdu_ready  = !full && !lsu_valid;
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign starve     = !empty && (cnt_q == LIM);
    assign head_ent   = mem_q[rd_ptr_q[AW-1:0]];

    assign push     = !full && (lsu_valid || mdu_valid);
    assign push_ent = lsu_valid ? '{rd: lsu_rd, data: lsu_data} : '{rd: mdu_rd, data: mdu_data};
`ifdef WB_X0_DROP_EN
    assign push_en  = push && (push_ent.rd != 5'd0);
`else
    assign push_en  = push;
`endif

    always_comb begin
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cnt_d     = 8'd0;
        pop       = 1'b0;
        alu_stall = 1'b0;
        if (starve) begin
            pop       = 1'b1;
            alu_stall = alu_valid;
        end else if (alu_valid) begin
            if (!empty)
                cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + 8'd1;
`ifdef WB_X0_DROP_EN
            if (alu_rd != 5'd0) begin
`else
            begin
`endif
                wen_d   = 1'b1;
                waddr_d = alu_rd;
                wdata_d = alu_data;
            end
        end else if (!empty) begin
            pop = 1'b1;
        end
        if (pop) begin
            wen_d   = 1'b1;
            waddr_d = head_ent.rd;
            wdata_d = head_ent.data;
        end
    end

    // Head and tail never alias while both push and pop are live, so the valid updates don't collide.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_en};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        mem_d     = mem_q;
        ent_vld_d = ent_vld_q;
        if (pop)
            ent_vld_d[rd_ptr_q[AW-1:0]] = 1'b0;
        if (push_en) begin
            mem_d[wr_ptr_q[AW-1:0]]     = push_ent;
            ent_vld_d[wr_ptr_q[AW-1:0]] = 1'b1;
        end
    end

    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_vld_q[i])
                pend_mask[mem_q[i].rd] = 1'b1;
`ifdef WB_X0_DROP_EN
        pend_mask[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ent_vld_q <= '0;
            cnt_q     <= 8'd0;
            wen_q     <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ent_vld_q <= ent_vld_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            mem_q     <= mem_d;
        end
    end

    assign wrd    = wen_q;
    assign addr_d = waddr_q;
    assign d      = wdata_q;
endmodule
